// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage controller: FSM state encoding,
// default widths and the timeout counter width function.
package mem_stage_ctrl_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-cycle timeout still needs a 1-bit counter.
  function automatic int ctr_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-cycle counter for the data-memory access; expire flags the
// last permitted BUSY cycle (count == TIMEOUT-1).
module mem_timeout_ctr
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: passes ALU results to MEM/WB in one cycle and runs
// loads/stores over a req/ack data-memory port, stalling the pipe meanwhile.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DW      = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic          mwmem,
  input  logic [4:0]    mdestReg,
  input  logic [DW-1:0] mr,
  input  logic [DW-1:0] mqb,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          stall,
  output logic          wwreg,
  output logic          wm2reg,
  output logic [4:0]    wdestReg,
  output logic [DW-1:0] wr,
  output logic [DW-1:0] wmo,
  output logic          err_misal,
  output logic          err_tmo
);

  state_t state, state_nxt;

  logic          memop, misal;
  logic          req_c, stall_c, capture, ack_hit, set_misal, set_tmo;
  logic          ctr_clr, ctr_en, ctr_expire;

  logic          cap_we, cap_wreg, cap_m2reg, cap_tmo;
  logic [4:0]    cap_dest;
  logic [DW-1:0] cap_addr, cap_wdata, cap_rdata;

  assign memop = mm2reg | mwmem;
  assign misal = (mr[1:0] != 2'b00);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clr),
    .enable (ctr_en),
    .expire (ctr_expire)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    capture   = 1'b0;
    ack_hit   = 1'b0;
    set_misal = 1'b0;
    set_tmo   = 1'b0;
    ctr_clr   = 1'b1;
    ctr_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if (memop) begin
          if (misal) begin
            set_misal = 1'b1;
          end else begin
            stall_c   = 1'b1;
            capture   = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        ctr_clr = 1'b0;
        if (dmem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (ctr_expire) begin
          set_tmo   = 1'b1;
          state_nxt = DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gating with rst drops the request and the stall in the reset cycle itself.
  assign dmem_req   = req_c & ~rst;
  assign stall      = stall_c & ~rst;
  assign dmem_we    = cap_we;
  assign dmem_addr  = cap_addr;
  assign dmem_wdata = cap_wdata;

  // NOTE: the capture registers are reset too, because they drive the memory
  // port directly and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cap_we    <= 1'b0;
      cap_wreg  <= 1'b0;
      cap_m2reg <= 1'b0;
      cap_tmo   <= 1'b0;
      cap_dest  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_rdata <= '0;
      err_misal <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_we    <= mwmem & ~mm2reg;
        cap_wreg  <= mwreg;
        cap_m2reg <= mm2reg;
        cap_dest  <= mdestReg;
        cap_addr  <= mr;
        cap_wdata <= mqb;
        cap_rdata <= '0;
        cap_tmo   <= 1'b0;
      end
      if (ack_hit && !cap_we) cap_rdata <= dmem_rdata;
      if (set_tmo)            cap_tmo   <= 1'b1;
      if (set_misal)          err_misal <= 1'b1;
      if (set_tmo)            err_tmo   <= 1'b1;
    end
  end

  // MEM/WB register: pass-through, completed access, or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wdestReg <= '0;
      wr       <= '0;
      wmo      <= '0;
    end else if (state == IDLE && !memop) begin
      wwreg    <= mwreg;
      wm2reg   <= mm2reg;
      wdestReg <= mdestReg;
      wr       <= mr;
      wmo      <= '0;
    end else if (state == DONE) begin
      wwreg    <= cap_wreg & ~cap_tmo;
      wm2reg   <= cap_m2reg;
      wdestReg <= cap_dest;
      wr       <= cap_addr;
      wmo      <= cap_rdata;
    end else begin
      wwreg    <= 1'b0;
      wm2reg   <= 1'b0;
      wdestReg <= '0;
      wr       <= '0;
      wmo      <= '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios then random instructions,
// checked against a per-instruction transaction model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 4;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mwreg, mm2reg, mwmem;
  logic [4:0]    mdestReg;
  logic [DW-1:0] mr, mqb;
  logic          dmem_req, dmem_we, dmem_ack;
  logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic          stall, wwreg, wm2reg, err_misal, err_tmo;
  logic [4:0]    wdestReg;
  logic [DW-1:0] wr, wmo;

  int checks = 0;
  int errors = 0;
  logic exp_misal = 1'b0;
  logic exp_tmo   = 1'b0;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .mdestReg   (mdestReg),
    .mr         (mr),
    .mqb        (mqb),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .stall      (stall),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wdestReg   (wdestReg),
    .wr         (wr),
    .wmo        (wmo),
    .err_misal  (err_misal),
    .err_tmo    (err_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                       input logic [4:0] dest, input logic [31:0] r, input logic [31:0] qb);
    mwreg = wreg; mm2reg = m2reg; mwmem = wmem; mdestReg = dest; mr = r; mqb = qb;
  endtask

  // One instruction from presentation to its MEM/WB result. ack_delay is the
  // number of request cycles without ack before the ack (negative = never).
  task automatic run_instr(input logic wreg, input logic m2reg, input logic wmem,
                           input logic [4:0] dest, input logic [31:0] r, input logic [31:0] qb,
                           input int ack_delay, input logic [31:0] rdata, input logic stray);
    bit memop, misal, tmo, done, first;
    int exp_req, exp_stall, n_req, n_stall;
    logic          e_wreg, e_m2reg;
    logic [4:0]    e_dest;
    logic [31:0]   e_wr, e_wmo;

    memop = m2reg | wmem;
    misal = (r % 4) != 0;
    tmo   = (ack_delay < 0) || (ack_delay >= TIMEOUT);
    if (!memop) begin
      exp_req = 0; exp_stall = 0;
      e_wreg = wreg; e_m2reg = m2reg; e_dest = dest; e_wr = r; e_wmo = 0;
    end else if (misal) begin
      exp_req = 0; exp_stall = 0;
      e_wreg = 0; e_m2reg = 0; e_dest = 0; e_wr = 0; e_wmo = 0;
      exp_misal = 1'b1;
    end else begin
      exp_req   = tmo ? TIMEOUT : ack_delay + 1;
      exp_stall = exp_req + 1;
      e_wreg = tmo ? 1'b0 : wreg;
      e_m2reg = m2reg; e_dest = dest; e_wr = r;
      e_wmo  = (!tmo && m2reg) ? rdata : 32'h0;
      if (tmo) exp_tmo = 1'b1;
    end

    drive(wreg, m2reg, wmem, dest, r, qb);
    n_req = 0; n_stall = 0; done = 0; first = 1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (dmem_req) begin
        check("req_addr", dmem_addr, r);
        check("req_we", dmem_we, wmem & ~m2reg);
        check("req_wdata", dmem_wdata, qb);
        dmem_ack   = (n_req == ack_delay);
        dmem_rdata = rdata;
        n_req++;
      end else begin
        dmem_ack   = first ? stray : 1'b0;
        dmem_rdata = ~rdata;
      end
      if (stall) begin
        if (!first) check("stall_bubble", wwreg, 1'b0);
        n_stall++;
      end else begin
        done = 1;
      end
      first = 0;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    check("bounded", done, 1'b1);
    check("stall_cycles", n_stall, exp_stall);
    check("req_cycles", n_req, exp_req);
    check("wwreg", wwreg, e_wreg);
    check("wm2reg", wm2reg, e_m2reg);
    check("wdestReg", wdestReg, e_dest);
    check("wr", wr, e_wr);
    check("wmo", wmo, e_wmo);
    check("err_misal", err_misal, exp_misal);
    check("err_tmo", err_tmo, exp_tmo);
  endtask

  initial begin
    int n;
    logic [31:0] r;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_wwreg", wwreg, 0);
    check("rst_wr", wr, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_errs", {err_misal, err_tmo}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(1, 0, 0, 5'd5, 32'h10, 32'h0, -1, 32'h0, 0);            // ALU op
    run_instr(1, 1, 0, 5'd7, 32'h40, 32'h0, 0, 32'hDEADBEEF, 0);      // load, ack first cycle
    run_instr(0, 0, 1, 5'd3, 32'h80, 32'h1234, 3, 32'h5555AAAA, 0);   // store, 3 waits
    run_instr(1, 1, 0, 5'd9, 32'h100, 32'h0, -1, 32'h0, 0);           // timeout
    run_instr(1, 1, 0, 5'd4, 32'h42, 32'h0, 0, 32'h0, 0);             // misaligned
    run_instr(1, 1, 1, 5'd6, 32'h44, 32'h77, 1, 32'hCAFEF00D, 1);     // both set -> load, stray ack

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      run_instr($urandom_range(0, 1), n[0], n[1], 5'($urandom), r, $urandom,
                $urandom_range(0, TIMEOUT + 1) - 1, $urandom, $urandom_range(0, 1));
    end

    // Reset during the second BUSY cycle.
    drive(1, 1, 0, 5'd2, 32'h20, 32'h0);
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
      @(negedge clk);
      if (dmem_req) n++;
      if (n < 2) begin @(posedge clk); #1; end
    end
    check("rst_reached_busy2", n, 2);
    rst = 1'b1; #1;
    check("rst_req_same_cycle", dmem_req, 0);
    check("rst_stall_same_cycle", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; exp_misal = 1'b0; exp_tmo = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_req", dmem_req, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_errs", {err_misal, err_tmo}, {exp_misal, exp_tmo});
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", dmem_req, 0);
    check("late_ack_wwreg", wwreg, 0);
    check("late_ack_wmo", wmo, 0);
    check("late_ack_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
